// File: rtl/tdp_ram_ctrl.sv
// tdp_ram_ctrl: true dual-port RAM with post-reset clear, same-address
// collision arbitration and a selectable 1- or 2-cycle read latency.
module tdp_ram_ctrl #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [WIDTH/8-1:0]   a_be,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [WIDTH-1:0]     a_wdata,
    output logic [WIDTH-1:0]     a_rdata,
    output logic                 a_rvalid,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [WIDTH/8-1:0]   b_be,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [WIDTH-1:0]     b_wdata,
    output logic [WIDTH-1:0]     b_rdata,
    output logic                 b_rvalid,
    output logic                 ready,
    output logic                 init_done,
    output logic                 collision
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int          NB    = WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
    logic                ready_q;
    logic                coll_q;

    logic [WIDTH-1:0]    mem [DEPTH];

    logic                a_acc, b_acc, a_wr, b_wr, a_rd, b_rd;
    logic                same_addr, b_wr_en, coll_d;

    logic                a_v1_q, a_v2_q, b_v1_q, b_v2_q;
    logic [WIDTH-1:0]    a_d1_q, a_d2_q, b_d1_q, b_d2_q;

    assign a_acc     = a_req & ready_q;
    assign b_acc     = b_req & ready_q;
    assign a_wr      = a_acc & a_we;
    assign b_wr      = b_acc & b_we;
    assign a_rd      = a_acc & ~a_we;
    assign b_rd      = b_acc & ~b_we;
    assign same_addr = (a_addr == b_addr);
    // Port A wins a same-address write/write conflict.
    assign b_wr_en   = b_wr & ~(a_wr & same_addr);
    assign coll_d    = a_acc & b_acc & same_addr & (a_we | b_we);

    // Next-state logic for the IDLE -> INIT -> RUN sequence and clear counter.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            StIdle: begin
                clr_d   = '0;
                state_d = (CLEAR_ON_RESET != 0) ? StInit : StRun;
            end
            StInit: begin
                clr_d = clr_q + ADDR_W'(1);
                if (&clr_q) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Control state: FSM, clear counter, registered ready and collision pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            clr_q   <= '0;
            ready_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ready_q <= (state_q == StRun);
            coll_q  <= coll_d;
        end
    end

    // Array writes: clear sequence during INIT, byte-enabled port writes in RUN.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[clr_q] <= '0;
        end else begin
            if (a_wr) begin
                for (int i = 0; i < NB; i++) begin
                    if (a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
                end
            end
            if (b_wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read pipelines; the array read samples pre-write data on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_v1_q <= 1'b0;
            a_v2_q <= 1'b0;
            b_v1_q <= 1'b0;
            b_v2_q <= 1'b0;
            a_d1_q <= '0;
            a_d2_q <= '0;
            b_d1_q <= '0;
            b_d2_q <= '0;
        end else begin
            a_v1_q <= a_rd;
            b_v1_q <= b_rd;
            a_v2_q <= a_v1_q;
            b_v2_q <= b_v1_q;
            if (a_rd)   a_d1_q <= mem[a_addr];
            if (b_rd)   b_d1_q <= mem[b_addr];
            if (a_v1_q) a_d2_q <= a_d1_q;
            if (b_v1_q) b_d2_q <= b_d1_q;
        end
    end

    assign a_rvalid  = (RD_LAT == 2) ? a_v2_q : a_v1_q;
    assign a_rdata   = (RD_LAT == 2) ? a_d2_q : a_d1_q;
    assign b_rvalid  = (RD_LAT == 2) ? b_v2_q : b_v1_q;
    assign b_rdata   = (RD_LAT == 2) ? b_d2_q : b_d1_q;
    assign ready     = ready_q;
    assign init_done = ready_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_tdp_ram_ctrl.sv
// Scoreboard bench for tdp_ram_ctrl: two instances (RD_LAT=1 and RD_LAT=2)
// share one stimulus stream; a negedge monitor checks every rvalid/collision.
module tb_tdp_ram_ctrl;

    localparam int W     = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [3:0]    a_be, b_be;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, b_wdata;

    logic [W-1:0]  a1_rdata, b1_rdata, a2_rdata, b2_rdata;
    logic          a1_rvalid, b1_rvalid, a2_rvalid, b2_rvalid;
    logic          ready1, ready2, init1, init2, coll1, coll2;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   coll_due[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    tdp_ram_ctrl #(.WIDTH(W), .ADDR_W(AW), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a1_rdata), .a_rvalid(a1_rvalid),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b1_rdata), .b_rvalid(b1_rvalid),
        .ready(ready1), .init_done(init1), .collision(coll1)
    );

    tdp_ram_ctrl #(.WIDTH(W), .ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a2_rdata), .a_rvalid(a2_rvalid),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b2_rdata), .b_rvalid(b2_rvalid),
        .ready(ready2), .init_done(init2), .collision(coll2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int p, input logic [31:0] dat, input int due);
        exp_t e;
        e.port = p;
        e.data = dat;
        e.due  = due;
        sb.push_back(e);
    endtask

    // Drive one cycle of requests at a negedge; queue the hand-computed results.
    // Ports 0/1 = A/B of the RD_LAT=1 instance, ports 2/3 = A/B of RD_LAT=2.
    task automatic step(input logic ar, input logic aw, input logic [3:0] abe,
                        input logic [3:0] aad, input logic [31:0] awd, input logic [31:0] aexp,
                        input logic br, input logic bw, input logic [3:0] bbe,
                        input logic [3:0] bad, input logic [31:0] bwd, input logic [31:0] bexp,
                        input logic coll);
        a_req = ar; a_we = aw; a_be = abe; a_addr = aad; a_wdata = awd;
        b_req = br; b_we = bw; b_be = bbe; b_addr = bad; b_wdata = bwd;
        if (ar && !aw) begin
            push_exp(0, aexp, cyc + 1);
            push_exp(2, aexp, cyc + 2);
        end
        if (br && !bw) begin
            push_exp(1, bexp, cyc + 1);
            push_exp(3, bexp, cyc + 2);
        end
        if (coll) coll_due.push_back(cyc + 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_flags1", {27'b0, ready1, init1, coll1, a1_rvalid, b1_rvalid}, 32'h0);
        chk("rst_flags2", {27'b0, ready2, init2, coll2, a2_rvalid, b2_rvalid}, 32'h0);
        chk("rst_a1_rdata", a1_rdata, 32'h0);
        chk("rst_b1_rdata", b1_rdata, 32'h0);
        chk("rst_a2_rdata", a2_rdata, 32'h0);
        chk("rst_b2_rdata", b2_rdata, 32'h0);
    endtask

    // rel = cycle count at the negedge where rst was released.
    task automatic wait_ready(input int rel);
        int t;
        t = 0;
        while (!(ready1 && ready2) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_rise_cycle", 32'(cyc), 32'(rel + DEPTH + 2));
        chk("ready_init_done", {28'b0, ready1, ready2, init1, init2}, 32'hF);
    endtask

    // Monitor: pops the scoreboard on every rvalid and checks collision each cycle.
    always @(negedge clk) begin : mon
        logic [3:0]  v;
        logic [31:0] d [4];
        int          idx;
        int          i;
        logic        ce;
        v    = {b2_rvalid, a2_rvalid, b1_rvalid, a1_rvalid};
        d[0] = a1_rdata;
        d[1] = b1_rdata;
        d[2] = a2_rdata;
        d[3] = b2_rdata;
        for (int p = 0; p < 4; p++) begin
            if (v[p]) begin
                idx = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (sb[k].port == p) begin
                        idx = k;
                        break;
                    end
                end
                if (idx < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid port%0d: got rvalid=1 data %h required rvalid=0",
                             p, d[p]);
                end else begin
                    chk($sformatf("rdata_port%0d", p), d[p], sb[idx].data);
                    chk($sformatf("rlat_port%0d", p), 32'(cyc), 32'(sb[idx].due));
                    sb.delete(idx);
                end
            end
        end
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_rvalid port%0d: got no rvalid required rvalid at cycle %0d",
                         sb[i].port, sb[i].due);
                sb.delete(i);
            end else begin
                i++;
            end
        end
        ce = (coll_due.size() > 0) && (coll_due[0] == cyc);
        if (ce) void'(coll_due.pop_front());
        chk("collision1", {31'b0, coll1}, {31'b0, ce});
        chk("collision2", {31'b0, coll2}, {31'b0, ce});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1);
    end

    initial begin
        int rel;
        rst = 1'b1;
        a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        chk_reset();

        // Release reset; requests during IDLE/INIT must be ignored.
        rel = cyc;
        rst = 1'b0;
        a_req = 1; a_we = 0; a_addr = 4'd4;
        b_req = 1; b_we = 0; b_addr = 4'd5;
        repeat (10) @(negedge clk);
        idle(0);
        wait_ready(rel);

        // Every word reads zero after the clear.
        for (int i = 0; i < 16; i++)
            step(1, 0, 4'h0, 4'(i), 32'h0, 32'h0, 1, 0, 4'h0, 4'(15 - i), 32'h0, 32'h0, 0);
        idle(3);

        // Byte enables, all-zero be, and same-address dual read.
        step(1, 1, 4'hF, 4'd3, 32'hAABBCCDD, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
        step(1, 1, 4'h5, 4'd3, 32'h11223344, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
        step(0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 1, 0, 4'h0, 4'd3, 32'h0, 32'hAA22CC44, 0);
        step(1, 1, 4'h0, 4'd3, 32'hFFFFFFFF, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
        step(1, 0, 4'h0, 4'd3, 32'h0, 32'hAA22CC44, 1, 0, 4'h0, 4'd3, 32'h0, 32'hAA22CC44, 0);
        idle(3);

        // Write/write collision: A wins.
        step(1, 1, 4'hF, 4'd5, 32'h1, 32'h0, 1, 1, 4'hF, 4'd5, 32'h2, 32'h0, 1);
        step(1, 0, 4'h0, 4'd5, 32'h0, 32'h1, 1, 0, 4'h0, 4'd6, 32'h0, 32'h0, 0);
        idle(3);

        // Read during write, both directions: reader sees old data.
        step(1, 1, 4'hF, 4'd7, 32'h55, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
        step(1, 1, 4'hF, 4'd7, 32'h99, 32'h0, 1, 0, 4'h0, 4'd7, 32'h0, 32'h55, 1);
        step(1, 0, 4'h0, 4'd7, 32'h0, 32'h99, 1, 0, 4'h0, 4'd7, 32'h0, 32'h99, 0);
        step(1, 0, 4'h0, 4'd8, 32'h0, 32'h0, 1, 1, 4'hF, 4'd8, 32'h77, 32'h0, 1);
        step(1, 0, 4'h0, 4'd8, 32'h0, 32'h77, 0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
        idle(3);

        // Streaming: fill, then 16 back-to-back reads per port.
        for (int i = 0; i < 8; i++)
            step(1, 1, 4'hF, 4'(i), 32'hC0DE0000 | 32'(i), 32'h0,
                 1, 1, 4'hF, 4'(i + 8), 32'hC0DE0000 | 32'(i + 8), 32'h0, 0);
        for (int i = 0; i < 16; i++)
            step(1, 0, 4'h0, 4'(i), 32'h0, 32'hC0DE0000 | 32'(i),
                 1, 0, 4'h0, 4'((i + 8) % 16), 32'h0, 32'hC0DE0000 | 32'((i + 8) % 16), 0);
        idle(4);

        // Reset one cycle after a read: RD_LAT=2 instance must never answer it.
        step(1, 0, 4'h0, 4'd2, 32'h0, 32'hC0DE0002, 0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
        a_req = 1'b0;
        b_req = 1'b0;
        #1;
        rst = 1'b1;
        sb.delete();
        coll_due.delete();
        #1;
        chk_reset();
        repeat (3) @(negedge clk);
        chk_reset();

        // Reset in the middle of INIT; clear restarts and covers all words.
        rel = cyc;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset();
        repeat (2) @(negedge clk);
        rel = cyc;
        rst = 1'b0;
        wait_ready(rel);
        step(1, 0, 4'h0, 4'd2, 32'h0, 32'h0, 1, 0, 4'h0, 4'd9, 32'h0, 32'h0, 0);
        step(1, 0, 4'h0, 4'd15, 32'h0, 32'h0, 1, 0, 4'h0, 4'd3, 32'h0, 32'h0, 0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
